branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 197 +++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Resolves up to LANES EXE branches/cycle; redirect and ds_nullify are registered (1 cycle); BPU update FIFO drains on valid/ready, drops on full.
// Optional BRANCH_LIKELY_EN: not-taken likely branches pulse ds_nullify; otherwise ex_likely is ignored and ds_nullify stays 0.
module branch_resolve_unit #(
    parameter int LANES     = 2,
    parameter int UPD_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_stall,
    input  logic [LANES-1:0]    ex_valid,
    input  logic [3*LANES-1:0]  ex_br_code,
    input  logic [LANES-1:0]    ex_likely,
    input  logic [32*LANES-1:0] ex_op_a,
    input  logic [32*LANES-1:0] ex_op_b,
    input  logic [32*LANES-1:0] ex_pc,
    input  logic [32*LANES-1:0] ex_br_addr,
    input  logic [32*LANES-1:0] ex_jump_addr,
    input  logic [LANES-1:0]    ex_pred_taken,
    input  logic [32*LANES-1:0] ex_pred_target,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                ds_nullify,
    output logic                upd_valid,
    input  logic                upd_ready,
    output logic [31:0]         upd_pc,
    output logic [31:0]         upd_target,
    output logic                upd_taken,
    output logic [7:0]          upd_drop_cnt
);
    localparam int PW = $clog2(UPD_DEPTH);
    localparam int CW = PW + 1;
    localparam int XW = (CW > 4) ? CW : 4;

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state_q;
    logic              redirect_valid_q, ds_nullify_q;
    logic [31:0]       redirect_pc_q;
    logic [CW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]        drop_q, drop_d;

    logic [LANES-1:0]  act_dir, lane_mis, resolved, wr_en;
    logic [31:0]       act_tgt [LANES];
    logic [PW-1:0]     wr_slot [LANES];
    logic              resolve_en, mis_hit, nullify_hit, deq;
    logic [31:0]       mis_tgt;
    logic [CW-1:0]     used, free;
    logic [3:0]        cnt_res, cnt_enq, cnt_drop;
    logic [8:0]        drop_sum;

    logic [31:0]       pc_mem  [UPD_DEPTH];
    logic [31:0]       tgt_mem [UPD_DEPTH];
    logic              tk_mem  [UPD_DEPTH];

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic [31:0] a, b, pc, tgt;
        logic [2:0]  code;
        logic        dir;

        assign a    = ex_op_a[32*g +: 32];
        assign b    = ex_op_b[32*g +: 32];
        assign pc   = ex_pc[32*g +: 32];
        assign code = ex_br_code[3*g +: 3];

        always_comb begin
            case (code)
                3'd0:    dir = (a == b);
                3'd1:    dir = (a != b);
                3'd2:    dir = ~a[31];
                3'd3:    dir = ~a[31] && (a != 32'd0);
                3'd4:    dir = a[31] || (a == 32'd0);
                3'd5:    dir = a[31];
                default: dir = 1'b1;
            endcase
        end

        always_comb begin
            if (code == 3'd6)      tgt = ex_jump_addr[32*g +: 32];
            else if (code == 3'd7) tgt = a;
            else if (dir)          tgt = ex_br_addr[32*g +: 32];
            else                   tgt = pc + 32'd8;
        end

        assign act_dir[g]  = dir;
        assign act_tgt[g]  = tgt;
        assign lane_mis[g] = ex_valid[g] &&
                             ((dir != ex_pred_taken[g]) ||
                              (dir && (tgt != ex_pred_target[32*g +: 32])));
    end

    // Lanes younger than the first mispredict are on the wrong path.
    assign resolve_en = !ex_stall && (state_q == IDLE);

    always_comb begin
        resolved = '0;
        mis_hit  = 1'b0;
        mis_tgt  = '0;
        for (int i = 0; i < LANES; i++) begin
            if (resolve_en && ex_valid[i] && !mis_hit) begin
                resolved[i] = 1'b1;
                if (lane_mis[i]) begin
                    mis_hit = 1'b1;
                    mis_tgt = act_tgt[i];
                end
            end
        end
    end

`ifdef BRANCH_LIKELY_EN
    assign nullify_hit = |(resolved & ~act_dir & ex_likely);
`else
    logic unused_likely;
    assign unused_likely = ^ex_likely;
    assign nullify_hit   = 1'b0;
`endif

    assign used      = wr_ptr_q - rd_ptr_q;
    assign free      = CW'(UPD_DEPTH) - used;
    assign upd_valid = (wr_ptr_q != rd_ptr_q);
    assign deq       = upd_valid && upd_ready;

    // Free space is taken before this cycle's dequeue, so a full FIFO drops even when draining.
    always_comb begin
        cnt_res = '0;
        cnt_enq = '0;
        wr_en   = '0;
        for (int i = 0; i < LANES; i++) begin
            wr_slot[i] = wr_ptr_q[PW-1:0] + PW'(cnt_enq);
            if (resolved[i]) begin
                cnt_res = cnt_res + 4'd1;
                if (XW'(cnt_enq) < XW'(free)) begin
                    wr_en[i] = 1'b1;
                    cnt_enq  = cnt_enq + 4'd1;
                end
            end
        end
        cnt_drop = cnt_res - cnt_enq;
        drop_sum = 9'(drop_q) + 9'(cnt_drop);
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        wr_ptr_d = wr_ptr_q + CW'(cnt_enq);
        rd_ptr_d = deq ? (rd_ptr_q + CW'(1)) : rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (!rst && wr_en[i]) begin
                pc_mem[wr_slot[i]]  <= ex_pc[32*i +: 32];
                tgt_mem[wr_slot[i]] <= act_tgt[i];
                tk_mem[wr_slot[i]]  <= act_dir[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            drop_q   <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ds_nullify_q     <= 1'b0;
        end else begin
            redirect_valid_q <= 1'b0;
            ds_nullify_q     <= nullify_hit;
            case (state_q)
                IDLE: begin
                    if (mis_hit) begin
                        state_q          <= FLUSH;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mis_tgt;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign ds_nullify     = ds_nullify_q;
    assign upd_pc         = pc_mem[rd_ptr_q[PW-1:0]];
    assign upd_target     = tgt_mem[rd_ptr_q[PW-1:0]];
    assign upd_taken      = tk_mem[rd_ptr_q[PW-1:0]];
    assign upd_drop_cnt   = drop_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
    localparam int L = 2;
    localparam int D = 8;

    logic            clk = 1'b0;
    logic            rst, ex_stall, upd_ready;
    logic [L-1:0]    ex_valid, ex_likely, ex_pred_taken;
    logic [3*L-1:0]  ex_br_code;
    logic [32*L-1:0] ex_op_a, ex_op_b, ex_pc, ex_br_addr, ex_jump_addr, ex_pred_target;
    logic            redirect_valid, ds_nullify, upd_valid, upd_taken;
    logic [31:0]     redirect_pc, upd_pc, upd_target;
    logic [7:0]      upd_drop_cnt;

    always #5 clk = ~clk;

    branch_resolve_unit #(.LANES(L), .UPD_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .ex_valid(ex_valid),
        .ex_br_code(ex_br_code), .ex_likely(ex_likely), .ex_op_a(ex_op_a),
        .ex_op_b(ex_op_b), .ex_pc(ex_pc), .ex_br_addr(ex_br_addr),
        .ex_jump_addr(ex_jump_addr), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .ds_nullify(ds_nullify), .upd_valid(upd_valid),
        .upd_ready(upd_ready), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_drop_cnt(upd_drop_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          m_drop;
    bit          m_flush, m_rv, m_dsn, m_rpc_chk;
    logic [31:0] m_rpc;
    int          n_chk, n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_dir(input int code, input logic [31:0] a, input logic [31:0] b);
        case (code)
            0:       return a == b;
            1:       return a != b;
            2:       return $signed(a) >= 0;
            3:       return $signed(a) > 0;
            4:       return $signed(a) <= 0;
            5:       return $signed(a) < 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_tgt(input int code, input bit d, input logic [31:0] a,
                                            input logic [31:0] pc, input logic [31:0] br,
                                            input logic [31:0] jp);
        if (code == 6) return jp;
        if (code == 7) return a;
        return d ? br : pc + 32'd8;
    endfunction

    task automatic model_step();
        bit          deq, d;
        int          space, code;
        logic [31:0] a, t;
        ent_t        e;
        deq       = (q.size() != 0) && upd_ready;
        space     = D - q.size();
        m_rv      = 0;
        m_dsn     = 0;
        m_rpc_chk = 0;
        if (rst) begin
            q.delete();
            m_drop    = 0;
            m_flush   = 0;
            m_rpc     = 0;
            m_rpc_chk = 1;
            return;
        end
        if (m_flush) m_flush = 0;
        else if (!ex_stall) begin
            for (int i = 0; i < L; i++) begin
                if (ex_valid[i]) begin
                    code = int'(ex_br_code[3*i +: 3]);
                    a    = ex_op_a[32*i +: 32];
                    d    = ref_dir(code, a, ex_op_b[32*i +: 32]);
                    t    = ref_tgt(code, d, a, ex_pc[32*i +: 32], ex_br_addr[32*i +: 32],
                                   ex_jump_addr[32*i +: 32]);
                    if (space > 0) begin
                        e.pc = ex_pc[32*i +: 32]; e.tk = d; e.tgt = t;
                        q.push_back(e);
                        space--;
                    end else if (m_drop < 255) m_drop++;
`ifdef BRANCH_LIKELY_EN
                    if (ex_likely[i] && !d) m_dsn = 1;
`endif
                    if (d != ex_pred_taken[i] || (d && t != ex_pred_target[32*i +: 32])) begin
                        m_rv = 1; m_rpc = t; m_rpc_chk = 1; m_flush = 1;
                        break;
                    end
                end
            end
        end
        if (deq) void'(q.pop_front());
    endtask

    task automatic compare();
        check_eq("redirect_valid", redirect_valid, m_rv);
        check_eq("ds_nullify", ds_nullify, m_dsn);
        check_eq("upd_valid", upd_valid, q.size() != 0);
        check_eq("upd_drop_cnt", upd_drop_cnt, m_drop);
        if (m_rpc_chk) check_eq("redirect_pc", redirect_pc, m_rpc);
        if (q.size() != 0) begin
            check_eq("upd_pc", upd_pc, q[0].pc);
            check_eq("upd_taken", upd_taken, q[0].tk);
            check_eq("upd_target", upd_target, q[0].tgt);
        end
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_lanes();
        ex_valid = '0; ex_br_code = '0; ex_likely = '0; ex_op_a = '0; ex_op_b = '0;
        ex_pc = '0; ex_br_addr = '0; ex_jump_addr = '0; ex_pred_taken = '0; ex_pred_target = '0;
    endtask

    task automatic set_lane(input int i, input bit v, input logic [2:0] code, input bit lk,
                            input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                            input logic [31:0] br, input logic [31:0] jp, input bit pt,
                            input logic [31:0] ptg);
        ex_valid[i] = v; ex_br_code[3*i +: 3] = code; ex_likely[i] = lk;
        ex_op_a[32*i +: 32] = a; ex_op_b[32*i +: 32] = b; ex_pc[32*i +: 32] = pc;
        ex_br_addr[32*i +: 32] = br; ex_jump_addr[32*i +: 32] = jp;
        ex_pred_taken[i] = pt; ex_pred_target[32*i +: 32] = ptg;
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom % 6)
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'd5;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic rand_lanes();
        int          code;
        bit          d, pt;
        logic [31:0] a, b, pc, br, jp, t, ptg;
        for (int i = 0; i < L; i++) begin
            code = int'($urandom % 8);
            a = pick_op(); b = ($urandom % 2) ? a : pick_op();
            pc = $urandom & 32'hFFFF_FFFC; br = $urandom & 32'hFFFF_FFFC; jp = $urandom & 32'hFFFF_FFFC;
            d   = ref_dir(code, a, b);
            t   = ref_tgt(code, d, a, pc, br, jp);
            pt  = ($urandom % 5 == 0) ? !d : d;
            ptg = ($urandom % 6 == 0) ? t + 32'd4 : t;
            set_lane(i, ($urandom % 4) != 0, 3'(code), 1'($urandom % 2), a, b, pc, br, jp, pt, ptg);
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_drop = 0; m_flush = 0; m_rpc = 0;
        clear_lanes();
        rst = 1; ex_stall = 0; upd_ready = 0;
        step();
        step();
        rst = 0;

        // Correctly predicted taken BEQ
        set_lane(0, 1, 3'd0, 0, 32'd5, 32'd5, 32'h100, 32'h1000, 32'h0, 1, 32'h1000);
        step();
        check_eq("beq_no_redirect", redirect_valid, 0);
        check_eq("beq_upd_target", upd_target, 32'h1000);
        clear_lanes(); upd_ready = 1;
        step();

        // BNE mispredict in lane0 blocks lane1, then wrong-path cycle ignored
        set_lane(0, 1, 3'd1, 0, 32'd7, 32'd7, 32'h2000, 32'h3000, 32'h0, 1, 32'h3000);
        set_lane(1, 1, 3'd6, 0, 32'd0, 32'd0, 32'h2004, 32'h0, 32'h4000, 1, 32'h4000);
        step();
        check_eq("bne_redirect", redirect_valid, 1);
        check_eq("bne_redirect_pc", redirect_pc, 32'h2008);
        step();
        check_eq("flush_ignores", redirect_valid, 0);
        clear_lanes();
        step();

        // JR target mispredict
        set_lane(0, 1, 3'd7, 0, 32'h8000_0040, 32'd0, 32'h500, 32'h0, 32'h0, 1, 32'h8000_0044);
        step();
        check_eq("jr_redirect_pc", redirect_pc, 32'h8000_0040);
        clear_lanes();
        step();
        check_eq("jr_pulse_once", redirect_valid, 0);

        // Fill with ready low: 10 resolved into 8 slots
        rst = 1; step(); rst = 0; upd_ready = 0;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < 2; i++)
                set_lane(i, 1, 3'd0, 0, 32'd3, 32'd3, 32'h1000 + 32'(16*c + 4*i),
                         32'h9000 + 32'(16*c + 4*i), 32'h0, 1, 32'h9000 + 32'(16*c + 4*i));
            step();
        end
        check_eq("fill_drop_cnt", upd_drop_cnt, 2);
        check_eq("fill_head_pc", upd_pc, 32'h1000);
        clear_lanes(); upd_ready = 1;
        for (int c = 0; c < 8; c++) step();
        check_eq("drained", upd_valid, 0);

`ifdef BRANCH_LIKELY_EN
        set_lane(0, 1, 3'd5, 1, 32'd1, 32'd0, 32'h700, 32'h800, 32'h0, 0, 32'h0);
        step();
        check_eq("likely_nullify", ds_nullify, 1);
        check_eq("likely_no_redirect", redirect_valid, 0);
        clear_lanes();
        step();
        check_eq("likely_pulse_once", ds_nullify, 0);
`endif

        // Reset while in FLUSH overrides the wrong-path inputs
        set_lane(0, 1, 3'd1, 0, 32'd2, 32'd2, 32'h600, 32'h0, 32'h0, 1, 32'h0);
        step();
        rst = 1;
        step();
        check_eq("rst_flush_rv", redirect_valid, 0);
        check_eq("rst_flush_rpc", redirect_pc, 0);
        check_eq("rst_flush_uv", upd_valid, 0);
        rst = 0;

        // Random traffic with occasional reset
        for (int c = 0; c < 2000; c++) begin
            rand_lanes();
            ex_stall  = ($urandom % 8) == 0;
            upd_ready = 1'($urandom % 2);
            rst       = ($urandom % 64) == 0;
            step();
        end
        // Mostly blocked BPU to saturate the drop counter
        rst = 0;
        for (int c = 0; c < 800; c++) begin
            rand_lanes();
            ex_stall  = ($urandom % 8) == 0;
            upd_ready = ($urandom % 16) == 0;
            step();
        end
        check_eq("drop_saturated", upd_drop_cnt, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
